// File: rtl/memory_access_if.sv
// Data-memory request/response bus between the MEM stage and data memory.
// Ports: master drives req_valid/we/addr/wdata; slave drives req_ready/resp_*.
interface memory_access_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;

    modport master (
        output req_valid,
        output req_we,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  resp_valid,
        input  resp_rdata
    );

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output resp_valid,
        output resp_rdata
    );
endinterface

// File: rtl/memory_access.sv
// MEM stage: word loads/stores over a valid/ready bus, MEM/WB register,
// write-back mux and stall/fault generation for the hazard unit.
// Ports: clk, reset (sync, active-high); EX_MEM_* pipeline inputs;
//   dmem (master side of the memory bus); mem_stall, mem_fault;
//   MEM_WB_* pipeline outputs; wb_data (combinational write-back value).
module memory_access #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            EX_MEM_alu_out,
    input  logic [31:0]            EX_MEM_dataB,
    input  logic [4:0]             EX_MEM_rd,
    input  logic                   EX_MEM_mem_to_reg,
    input  logic                   EX_MEM_reg_write,
    input  logic                   EX_MEM_mem_read,
    input  logic                   EX_MEM_mem_write,
    memory_access_if.master        dmem,
    output logic                   mem_stall,
    output logic                   mem_fault,
    output logic [31:0]            MEM_WB_alu_out,
    output logic [31:0]            MEM_WB_read_data,
    output logic [4:0]             MEM_WB_rd,
    output logic                   MEM_WB_mem_to_reg,
    output logic                   MEM_WB_reg_write,
    output logic [31:0]            wb_data
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST =
        CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;

    logic access;
    logic is_write;
    logic misaligned;
    logic tmo_hit;
    logic req_valid;
    logic stall;
    logic abort;
    logic rd_done;
    logic fault_now;

    // A store with mem_read also set is still a store.
    assign access     = EX_MEM_mem_read | EX_MEM_mem_write;
    assign is_write   = EX_MEM_mem_write;
    assign misaligned = access & (EX_MEM_alu_out[1:0] != 2'b00);

    // Fires in the last allowed cycle, so an access spends exactly
    // TIMEOUT_CYCLES cycles in REQ/WAIT before the abort edge.
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (cnt == LAST);

    always_comb begin
        state_next = state;
        req_valid  = 1'b0;
        stall      = 1'b0;
        abort      = 1'b0;
        rd_done    = 1'b0;
        unique case (state)
            IDLE: begin
                if (access && !misaligned) begin
                    req_valid = 1'b1;
                    if (dmem.req_ready && is_write) begin
                        state_next = IDLE;
                    end else if (dmem.req_ready) begin
                        state_next = WAIT;
                        stall      = 1'b1;
                    end else begin
                        state_next = REQ;
                        stall      = 1'b1;
                    end
                end
            end
            REQ: begin
                req_valid = 1'b1;
                if (dmem.req_ready && is_write) begin
                    state_next = IDLE;
                end else if (tmo_hit) begin
                    // Abort wins over a read accepted in the same cycle;
                    // its late response is then dropped in IDLE.
                    state_next = IDLE;
                    abort      = 1'b1;
                end else if (dmem.req_ready) begin
                    state_next = WAIT;
                    stall      = 1'b1;
                end else begin
                    stall = 1'b1;
                end
            end
            WAIT: begin
                if (dmem.resp_valid) begin
                    state_next = IDLE;
                    rd_done    = 1'b1;
                end else if (tmo_hit) begin
                    state_next = IDLE;
                    abort      = 1'b1;
                end else begin
                    stall = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign fault_now = ((state == IDLE) && misaligned) | abort;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (state_next != state && state_next != IDLE) begin
            cnt <= '0;
        end else if (state != IDLE) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            MEM_WB_alu_out    <= '0;
            MEM_WB_read_data  <= '0;
            MEM_WB_rd         <= '0;
            MEM_WB_mem_to_reg <= 1'b0;
            MEM_WB_reg_write  <= 1'b0;
            mem_fault         <= 1'b0;
        end else begin
            mem_fault <= fault_now;
            if (stall) begin
                MEM_WB_reg_write <= 1'b0;
            end else begin
                MEM_WB_alu_out    <= EX_MEM_alu_out;
                MEM_WB_rd         <= EX_MEM_rd;
                MEM_WB_mem_to_reg <= EX_MEM_mem_to_reg;
                MEM_WB_reg_write  <= EX_MEM_reg_write & ~fault_now;
            end
            if (rd_done) begin
                MEM_WB_read_data <= dmem.resp_rdata;
            end
        end
    end

    assign dmem.req_valid = req_valid;
    assign dmem.req_we    = is_write;
    assign dmem.req_addr  = {EX_MEM_alu_out[31:2], 2'b00};
    assign dmem.req_wdata = EX_MEM_dataB;

    assign mem_stall = stall;
    assign wb_data   = MEM_WB_mem_to_reg ? MEM_WB_read_data : MEM_WB_alu_out;

endmodule
